router_fsm: RTL and testbench

- Packet-reception controller for the 3-port router.
- Decodes the header byte and sequences writes of header, payload and parity into the addressed output FIFO through the synchronizer.
- Stalls the source via `busy` while the FIFO is full or not yet drained.
- Aborts on per-port soft reset, and drops the packet if the destination FIFO stays non-empty too long.

---
 rtl/router_fsm_if.sv | 46 ++++
 rtl/router_fsm.sv | 167 ++++++++++++++++
 tb/tb_router_fsm.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_fsm_if.sv
// router_fsm_if
// Groups the packet-reception controller's handshake signals.
//   slave  : the FSM side. Packet, FIFO and soft-reset status come in;
//            state strobes, busy and drop_pkt go out.
//   master : the surrounding router side (synchronizer, register block,
//            packet source).
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
    logic       drop_pkt;

    modport slave (
        input  pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_pkt
    );

    modport master (
        output pkt_valid, data_in, fifo_full,
               fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_pkt
    );
endinterface

// File: rtl/router_fsm.sv
// router_fsm
// Packet-reception controller for the 3-port router. Decodes the header,
// sequences header/payload/parity writes into the addressed output FIFO,
// stalls the source with busy, and drops a packet whose destination FIFO
// does not drain within WTE_LIMIT cycles (0 = wait forever).
// Ports:
//   clock  : rising-edge system clock
//   reset  : synchronous, active-high reset
//   bus    : router_fsm_if.slave (packet/FIFO status in, state strobes out)
//
// state | meaning
// ------+--------------------------------------------------------------
// DA    | decode header address, idle
// WTE   | wait for the addressed FIFO to drain, source stalled
// LFD   | write header byte
// LD    | write payload bytes
// FFS   | addressed FIFO full, source stalled
// LAF   | write the byte held during the full stall
// LP    | write parity byte
// CPE   | parity check cycle, clears internal parity registers
// DROP  | discard the rest of a timed-out packet
module router_fsm #(
    parameter int WTE_LIMIT = 255,
    parameter int CNT_W     = 8
) (
    input  logic        clock,
    input  logic        reset,
    router_fsm_if.slave bus
);
    typedef enum logic [3:0] {
        ST_DA, ST_WTE, ST_LFD, ST_LD, ST_FFS, ST_LAF, ST_LP, ST_CPE, ST_DROP
    } state_t;

    localparam logic [CNT_W-1:0] WTE_LAST =
        (WTE_LIMIT == 0) ? '0 : CNT_W'(WTE_LIMIT - 1);

    state_t           state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             drop_first_q, drop_first_d;
    logic             drop_tail_q, drop_tail_d;

    logic [3:0]       empty_v, soft_v;
    logic             empty_sel, soft_sel;

    // Index 3 is an invalid address and is never captured; pad it to 0.
    assign empty_v   = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign soft_v    = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign empty_sel = empty_v[addr_q];
    assign soft_sel  = soft_v[addr_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_DA;
            addr_q       <= '0;
            wcnt_q       <= '0;
            drop_first_q <= 1'b0;
            drop_tail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wcnt_q       <= wcnt_d;
            drop_first_q <= drop_first_d;
            drop_tail_q  <= drop_tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            ST_DA: begin
                if (bus.pkt_valid && bus.data_in != 2'b11) begin
                    addr_d  = bus.data_in;
                    // addr_q is not yet valid here, so use the header itself.
                    state_d = empty_v[bus.data_in] ? ST_LFD : ST_WTE;
                end
            end
            ST_WTE: begin
                if (empty_sel)
                    state_d = ST_LFD;
                else if (WTE_LIMIT != 0 && wcnt_q == WTE_LAST)
                    state_d = ST_DROP;
            end
            ST_LFD:  state_d = ST_LD;
            ST_LD: begin
                if (bus.fifo_full)
                    state_d = ST_FFS;
                else if (!bus.pkt_valid)
                    state_d = ST_LP;
            end
            ST_FFS: begin
                if (!bus.fifo_full)
                    state_d = ST_LAF;
            end
            ST_LAF: begin
                if (bus.parity_done)
                    state_d = ST_DA;
                else if (bus.low_pkt_valid)
                    state_d = ST_LP;
                else
                    state_d = ST_LD;
            end
            ST_LP:   state_d = ST_CPE;
            // Full FIFO on the parity byte: retry it through FFS/LAF.
            ST_CPE:  state_d = bus.fifo_full ? ST_FFS : ST_DA;
            ST_DROP: begin
                // One extra cycle after pkt_valid falls swallows the parity byte.
                if (drop_tail_q)
                    state_d = ST_DA;
            end
            default: state_d = ST_DA;
        endcase

        if (state_q != ST_DA && soft_sel)
            state_d = ST_DA;

        // Counter is held at zero outside WTE, so it is clear on every entry.
        wcnt_d       = (state_q == ST_WTE) ? wcnt_q + CNT_W'(1) : '0;
        drop_first_d = (state_q == ST_WTE) && (state_d == ST_DROP);
        drop_tail_d  = (state_q == ST_DROP) && (state_d == ST_DROP) && !bus.pkt_valid;
    end

    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.write_enb_reg = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.busy          = 1'b0;
        bus.drop_pkt      = drop_first_q;
        unique case (state_q)
            ST_DA:  bus.detect_add = 1'b1;
            ST_WTE: bus.busy = 1'b1;
            ST_LFD: begin
                bus.lfd_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b1;
            end
            ST_LD: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            ST_FFS: begin
                bus.full_state = 1'b1;
                bus.busy       = 1'b1;
            end
            ST_LAF: begin
                bus.laf_state     = 1'b1;
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b1;
            end
            ST_LP: begin
                bus.write_enb_reg = 1'b1;
                bus.busy          = 1'b1;
            end
            ST_CPE: begin
                bus.rst_int_reg = 1'b1;
                bus.busy        = 1'b1;
            end
            ST_DROP: ;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm
// Directed bench for router_fsm. Two instances: one with the default
// timeout (255) and one with WTE_LIMIT=4 for the drop scenario.
// Each step applies one input vector, waits one clock, and compares the
// packed output vector against a hand-derived expected state pattern.
module tb_router_fsm;
    logic clock;
    logic reset;

    router_fsm_if bus();
    router_fsm_if bus4();

    router_fsm dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    router_fsm #(.WTE_LIMIT(4), .CNT_W(8)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Output vector order:
    // {detect_add, lfd_state, ld_state, laf_state, full_state,
    //  write_enb_reg, rst_int_reg, busy, drop_pkt}
    localparam logic [8:0] O_DA   = 9'b100000000;
    localparam logic [8:0] O_WTE  = 9'b000000010;
    localparam logic [8:0] O_LFD  = 9'b010001010;
    localparam logic [8:0] O_LD   = 9'b001001000;
    localparam logic [8:0] O_FFS  = 9'b000010010;
    localparam logic [8:0] O_LAF  = 9'b000101010;
    localparam logic [8:0] O_LP   = 9'b000001010;
    localparam logic [8:0] O_CPE  = 9'b000000110;
    localparam logic [8:0] O_DRP1 = 9'b000000001;
    localparam logic [8:0] O_DRP  = 9'b000000000;

    typedef struct packed {
        logic       pv;
        logic [1:0] d;
        logic       ff;
        logic [2:0] emp;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [8:0] want;
    } vec_t;

    function automatic vec_t V(logic pv, logic [1:0] d, logic ff, logic [2:0] emp,
                               logic [2:0] sr, logic pd, logic lpv, logic [8:0] want);
        vec_t v;
        v.pv = pv; v.d = d; v.ff = ff; v.emp = emp;
        v.sr = sr; v.pd = pd; v.lpv = lpv; v.want = want;
        return v;
    endfunction

    task automatic drive_main(input vec_t v);
        bus.pkt_valid     = v.pv;
        bus.data_in       = v.d;
        bus.fifo_full     = v.ff;
        bus.fifo_empty_0  = v.emp[0];
        bus.fifo_empty_1  = v.emp[1];
        bus.fifo_empty_2  = v.emp[2];
        bus.soft_reset_0  = v.sr[0];
        bus.soft_reset_1  = v.sr[1];
        bus.soft_reset_2  = v.sr[2];
        bus.parity_done   = v.pd;
        bus.low_pkt_valid = v.lpv;
    endtask

    task automatic drive_4(input vec_t v);
        bus4.pkt_valid     = v.pv;
        bus4.data_in       = v.d;
        bus4.fifo_full     = v.ff;
        bus4.fifo_empty_0  = v.emp[0];
        bus4.fifo_empty_1  = v.emp[1];
        bus4.fifo_empty_2  = v.emp[2];
        bus4.soft_reset_0  = v.sr[0];
        bus4.soft_reset_1  = v.sr[1];
        bus4.soft_reset_2  = v.sr[2];
        bus4.parity_done   = v.pd;
        bus4.low_pkt_valid = v.lpv;
    endtask

    function automatic logic [8:0] obs_main();
        return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy,
                bus.drop_pkt};
    endfunction

    function automatic logic [8:0] obs_4();
        return {bus4.detect_add, bus4.lfd_state, bus4.ld_state, bus4.laf_state,
                bus4.full_state, bus4.write_enb_reg, bus4.rst_int_reg, bus4.busy,
                bus4.drop_pkt};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        drive_main(V(0, 0, 0, 3'b111, 0, 0, 0, O_DA));
        drive_4(V(0, 0, 0, 3'b111, 0, 0, 0, O_DA));
        reset = 1'b1;
        tick();
        tick();
        got = obs_main();
        total++;
        if (got !== O_DA) begin bad++; $display("FAIL reset_main got=%b want=%b", got, O_DA); end
        got = obs_4();
        total++;
        if (got !== O_DA) begin bad++; $display("FAIL reset_dut4 got=%b want=%b", got, O_DA); end
        reset = 1'b0;
        tick();
        got = obs_main();
        total++;
        if (got !== O_DA) begin bad++; $display("FAIL reset_idle got=%b want=%b", got, O_DA); end
    endtask

    task automatic test_basic();
        vec_t s[$];
        logic [8:0] got;
        int wen_cnt = 0;
        int rst_cnt = 0;
        s.push_back(V(1, 1, 0, 3'b111, 0, 0, 0, O_LFD));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LD));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LD));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LD));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LP));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_CPE));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_DA));
        foreach (s[i]) begin
            drive_main(s[i]);
            tick();
            got = obs_main();
            if (bus.write_enb_reg && !bus.busy) wen_cnt++;
            if (bus.lfd_state && bus.write_enb_reg) wen_cnt++;
            if (bus.rst_int_reg) rst_cnt++;
            total++;
            if (got !== s[i].want) begin
                bad++;
                $display("FAIL basic step %0d got=%b want=%b", i, got, s[i].want);
            end
        end
        // header + three payload bytes
        total++;
        if (wen_cnt !== 4) begin bad++; $display("FAIL basic_wen_cycles got=%0d want=4", wen_cnt); end
        total++;
        if (rst_cnt !== 1) begin bad++; $display("FAIL basic_rst_int_cycles got=%0d want=1", rst_cnt); end
    endtask

    task automatic test_wait_empty();
        vec_t s[$];
        logic [8:0] got;
        s.push_back(V(1, 2, 0, 3'b011, 0, 0, 0, O_WTE));
        // data_in now points at an empty FIFO; WTE must look at addr_reg only
        s.push_back(V(1, 0, 0, 3'b011, 0, 0, 0, O_WTE));
        s.push_back(V(1, 0, 0, 3'b011, 0, 0, 0, O_WTE));
        s.push_back(V(1, 0, 0, 3'b011, 0, 0, 0, O_WTE));
        s.push_back(V(1, 0, 0, 3'b011, 0, 0, 0, O_WTE));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LFD));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LD));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LP));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_CPE));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_DA));
        foreach (s[i]) begin
            drive_main(s[i]);
            tick();
            got = obs_main();
            total++;
            if (got !== s[i].want) begin
                bad++;
                $display("FAIL wait_empty step %0d got=%b want=%b", i, got, s[i].want);
            end
        end
    endtask

    task automatic test_fifo_full();
        vec_t s[$];
        logic [8:0] got;
        s.push_back(V(1, 1, 0, 3'b111, 0, 0, 0, O_LFD));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LD));
        s.push_back(V(1, 0, 1, 3'b111, 0, 0, 0, O_FFS));
        s.push_back(V(1, 0, 1, 3'b111, 0, 0, 0, O_FFS));
        s.push_back(V(1, 0, 1, 3'b111, 0, 0, 0, O_FFS));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LAF));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LD));
        s.push_back(V(1, 0, 1, 3'b111, 0, 0, 0, O_FFS));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LAF));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 1, O_LP));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_CPE));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_DA));
        s.push_back(V(1, 1, 0, 3'b111, 0, 0, 0, O_LFD));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LD));
        // fifo_full and end of packet together: full wins
        s.push_back(V(0, 0, 1, 3'b111, 0, 0, 0, O_FFS));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LAF));
        s.push_back(V(0, 0, 0, 3'b111, 0, 1, 0, O_DA));
        s.push_back(V(1, 1, 0, 3'b111, 0, 0, 0, O_LFD));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LD));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LP));
        s.push_back(V(0, 0, 1, 3'b111, 0, 0, 0, O_CPE));
        // full during parity check: retry parity byte
        s.push_back(V(0, 0, 1, 3'b111, 0, 0, 0, O_FFS));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LAF));
        s.push_back(V(0, 0, 0, 3'b111, 0, 1, 0, O_DA));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_DA));
        foreach (s[i]) begin
            drive_main(s[i]);
            tick();
            got = obs_main();
            total++;
            if (got !== s[i].want) begin
                bad++;
                $display("FAIL fifo_full step %0d got=%b want=%b", i, got, s[i].want);
            end
        end
    endtask

    task automatic test_soft_reset();
        vec_t s[$];
        logic [8:0] got;
        // soft reset is ignored while in DA
        s.push_back(V(1, 0, 0, 3'b111, 3'b001, 0, 0, O_LFD));
        s.push_back(V(1, 0, 0, 3'b111, 3'b000, 0, 0, O_LD));
        s.push_back(V(1, 0, 0, 3'b111, 3'b010, 0, 0, O_LD));
        s.push_back(V(1, 0, 0, 3'b111, 3'b001, 0, 0, O_DA));
        s.push_back(V(0, 0, 0, 3'b111, 3'b000, 0, 0, O_DA));
        s.push_back(V(1, 0, 0, 3'b111, 3'b000, 0, 0, O_LFD));
        s.push_back(V(1, 0, 0, 3'b111, 3'b000, 0, 0, O_LD));
        s.push_back(V(1, 0, 1, 3'b111, 3'b000, 0, 0, O_FFS));
        s.push_back(V(1, 0, 1, 3'b111, 3'b001, 0, 0, O_DA));
        s.push_back(V(0, 0, 0, 3'b111, 3'b000, 0, 0, O_DA));
        foreach (s[i]) begin
            drive_main(s[i]);
            tick();
            got = obs_main();
            total++;
            if (got !== s[i].want) begin
                bad++;
                $display("FAIL soft_reset step %0d got=%b want=%b", i, got, s[i].want);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t s[$];
        logic [8:0] got;
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LFD));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LD));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LP));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_CPE));
        s.push_back(V(1, 2, 0, 3'b111, 0, 0, 0, O_DA));
        s.push_back(V(1, 2, 0, 3'b111, 0, 0, 0, O_LFD));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LD));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LP));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_CPE));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_DA));
        foreach (s[i]) begin
            drive_main(s[i]);
            tick();
            got = obs_main();
            total++;
            if (got !== s[i].want) begin
                bad++;
                $display("FAIL back_to_back step %0d got=%b want=%b", i, got, s[i].want);
            end
        end
    endtask

    task automatic test_invalid_and_reset();
        vec_t s[$];
        logic [8:0] got;
        s.push_back(V(1, 3, 0, 3'b111, 0, 0, 0, O_DA));
        s.push_back(V(1, 3, 0, 3'b111, 0, 0, 0, O_DA));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_DA));
        s.push_back(V(1, 1, 0, 3'b111, 0, 0, 0, O_LFD));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LD));
        foreach (s[i]) begin
            drive_main(s[i]);
            tick();
            got = obs_main();
            total++;
            if (got !== s[i].want) begin
                bad++;
                $display("FAIL invalid step %0d got=%b want=%b", i, got, s[i].want);
            end
        end
        reset = 1'b1;
        tick();
        got = obs_main();
        total++;
        if (got !== O_DA) begin bad++; $display("FAIL reset_mid_ld got=%b want=%b", got, O_DA); end
        reset = 1'b0;
        drive_main(V(0, 0, 0, 3'b111, 0, 0, 0, O_DA));
        tick();
        got = obs_main();
        total++;
        if (got !== O_DA) begin bad++; $display("FAIL after_reset_idle got=%b want=%b", got, O_DA); end
    endtask

    task automatic test_drop();
        vec_t s[$];
        logic [8:0] got;
        s.push_back(V(1, 0, 0, 3'b110, 0, 0, 0, O_WTE));
        s.push_back(V(1, 0, 0, 3'b110, 0, 0, 0, O_WTE));
        s.push_back(V(1, 0, 0, 3'b110, 0, 0, 0, O_WTE));
        s.push_back(V(1, 0, 0, 3'b110, 0, 0, 0, O_WTE));
        s.push_back(V(1, 0, 0, 3'b110, 0, 0, 0, O_DRP1));
        s.push_back(V(1, 0, 0, 3'b110, 0, 0, 0, O_DRP));
        s.push_back(V(0, 0, 0, 3'b110, 0, 0, 0, O_DRP));
        s.push_back(V(0, 0, 0, 3'b110, 0, 0, 0, O_DA));
        s.push_back(V(1, 0, 0, 3'b111, 0, 0, 0, O_LFD));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LD));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_LP));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_CPE));
        s.push_back(V(0, 0, 0, 3'b111, 0, 0, 0, O_DA));
        foreach (s[i]) begin
            drive_4(s[i]);
            tick();
            got = obs_4();
            total++;
            if (got !== s[i].want) begin
                bad++;
                $display("FAIL drop step %0d got=%b want=%b", i, got, s[i].want);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        test_reset();
        test_basic();
        test_wait_empty();
        test_fifo_full();
        test_soft_reset();
        test_back_to_back();
        test_invalid_and_reset();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
